// File: rtl/craft_mix_columns_stream_pkg.sv
// craft_pkg: shared CRAFT cell width, MixColumns mode encodings and cell/column types.
package craft_pkg;
  localparam int CRAFT_CELL_W = 4;
  localparam logic MC_MODE_MIX = 1'b0;
  localparam logic MC_MODE_BYPASS = 1'b1;
  typedef logic [CRAFT_CELL_W-1:0] cell_t;
  typedef cell_t [3:0] column_t;
endpackage

// File: rtl/craft_mix_columns_stream_mc_column.sv
// craft_mc_column: combinational CRAFT MixColumns (or bypass) on one 4-cell column, row 0 in the low bits.
module craft_mc_column
  import craft_pkg::*;
#(
  parameter int CELL_W = CRAFT_CELL_W
) (
  input  logic [4*CELL_W-1:0] col_in,
  input  logic                mode,
  output logic [4*CELL_W-1:0] col_out
);
  logic [CELL_W-1:0] a, b, c, d;
  assign {d, c, b, a} = col_in;
  // The matrix is involutory, so this same network also serves as the inverse.
  assign col_out = (mode == MC_MODE_BYPASS) ? col_in : {d, c, b ^ d, a ^ c ^ d};
endmodule

// File: rtl/craft_mix_columns_stream.sv
// craft_mix_columns_stream: collects 4-cell columns LANES cells per beat, applies MixColumns
// or bypass, and streams them out; in_ready depends combinationally on out_ready.
module craft_mix_columns_stream
  import craft_pkg::*;
#(
  parameter int CELL_W = CRAFT_CELL_W,
  parameter int LANES = 1,
  parameter int COLS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*CELL_W-1:0] in_data,
  input  logic                    in_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*CELL_W-1:0] out_data,
  output logic                    out_last
);
  localparam int BEATS = 4 / LANES;
  localparam int LW = LANES * CELL_W;
  localparam int CW = 4 * CELL_W;
  localparam int CNT_W = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int COL_W = COLS > 1 ? $clog2(COLS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  logic [CNT_W-1:0] in_cnt, out_cnt;
  logic [COL_W-1:0] col_cnt;
  logic             out_full, mode_q, col_mode;
  logic             in_fire, in_end, out_fire, out_end;
  logic [CW-1:0]    col_buf, col_merged, col_mixed, out_buf;

  assign out_fire = out_full && out_ready;
  assign out_end = out_fire && out_cnt == LAST;
  assign in_ready = (in_cnt != LAST) || !out_full || (out_ready && out_cnt == LAST);
  assign in_fire = in_valid && in_ready;
  assign in_end = in_fire && in_cnt == LAST;
  assign out_valid = out_full;
  assign out_data = out_buf[int'(out_cnt)*LW +: LW];
  assign out_last = out_full && out_cnt == LAST && col_cnt == COL_LAST;

  // The final beat always carries the top rows, so it is merged straight into the transform.
  always_comb begin
    col_merged = col_buf;
    col_merged[CW-LW +: LW] = in_data;
  end

  assign col_mode = (in_cnt == '0) ? in_mode : mode_q;

  craft_mc_column #(.CELL_W(CELL_W)) u_col (
    .col_in (col_merged),
    .mode   (col_mode),
    .col_out(col_mixed)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt <= '0;
      mode_q <= MC_MODE_MIX;
      col_buf <= '0;
    end else if (in_fire) begin
      in_cnt <= in_end ? '0 : in_cnt + 1'b1;
      mode_q <= col_mode;
      col_buf[int'(in_cnt)*LW +: LW] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_full <= 1'b0;
      out_buf <= '0;
    end else begin
      out_full <= in_end ? 1'b1 : out_end ? 1'b0 : out_full;
      out_buf <= in_end ? col_mixed : out_buf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt <= '0;
      col_cnt <= '0;
    end else if (out_fire) begin
      out_cnt <= out_end ? '0 : out_cnt + 1'b1;
      col_cnt <= !out_end ? col_cnt : (col_cnt == COL_LAST) ? '0 : col_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_craft_mix_columns_stream.sv
// tb_craft_mix_columns_stream: randomized and directed checks of the MixColumns stream
// for LANES=1, 2 and 4 against a column-level reference model.
module tb_craft_mix_columns_stream;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic a_in_valid = 0, a_in_mode = 0, a_out_ready = 0;
  logic a_in_ready, a_out_valid, a_out_last;
  logic [3:0] a_in_data = '0, a_out_data;
  logic b_in_valid = 0, b_in_mode = 0, b_out_ready = 0;
  logic b_in_ready, b_out_valid, b_out_last;
  logic [7:0] b_in_data = '0, b_out_data;
  logic c_in_valid = 0, c_in_mode = 0, c_out_ready = 0;
  logic c_in_ready, c_out_valid, c_out_last;
  logic [15:0] c_in_data = '0, c_out_data;

  craft_mix_columns_stream #(.CELL_W(4), .LANES(1), .COLS(4)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_mode(a_in_mode), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .out_last(a_out_last));

  craft_mix_columns_stream #(.CELL_W(4), .LANES(2), .COLS(4)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_mode(b_in_mode), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last));

  craft_mix_columns_stream #(.CELL_W(4), .LANES(4), .COLS(4)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .in_mode(c_in_mode), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_data(c_out_data), .out_last(c_out_last));

  // Column model: rows a,b,c,d -> (a^c^d, b^d, c, d), or unchanged in bypass.
  function automatic logic [15:0] mc(input logic [15:0] col, input logic mode);
    logic [3:0] r[4];
    for (int k = 0; k < 4; k++) r[k] = col[4*k +: 4];
    if (mode) return col;
    return {r[3], r[2], r[1] ^ r[3], r[0] ^ r[2] ^ r[3]};
  endfunction

  // Feeds one column into the LANES=1 instance with out_ready high and checks data and latency.
  task automatic l1_column(input logic [15:0] col, input logic mode, input string tag);
    logic [15:0] exp;
    int i, got, acc;
    exp = mc(col, mode);
    i = 0; got = 0; acc = -10;
    a_out_ready = 1;
    for (int c = 0; c < 20 && got < 4; c++) begin
      @(negedge clk);
      a_in_valid = (i < 4);
      a_in_data = col[4*(i%4) +: 4];
      a_in_mode = (i == 0) ? mode : ~mode;
      #1;
      if (a_out_valid) begin
        checks++;
        if (a_out_data !== exp[4*got +: 4]) begin
          errors++;
          $display("FAIL %s beat%0d: got %h want %h", tag, got, a_out_data, exp[4*got +: 4]);
        end
        if (got == 0) begin
          checks++;
          if (c != acc + 1) begin
            errors++;
            $display("FAIL %s latency: first out at cycle %0d want %0d", tag, c, acc + 1);
          end
        end
        got++;
      end
      if (a_in_valid && a_in_ready) begin
        if (i == 3) acc = c;
        i++;
      end
    end
    a_in_valid = 0;
    checks++;
    if (got != 4) begin
      errors++;
      $display("FAIL %s timeout: got %0d beats want 4", tag, got);
    end
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (2) @(negedge clk);
    #1;
    checks += 9;
    if (a_out_valid !== 0) begin errors++; $display("FAIL reset a_out_valid: got %b want 0", a_out_valid); end
    if (a_in_ready !== 1) begin errors++; $display("FAIL reset a_in_ready: got %b want 1", a_in_ready); end
    if (a_out_data !== 0) begin errors++; $display("FAIL reset a_out_data: got %h want 0", a_out_data); end
    if (a_out_last !== 0) begin errors++; $display("FAIL reset a_out_last: got %b want 0", a_out_last); end
    if (b_out_valid !== 0) begin errors++; $display("FAIL reset b_out_valid: got %b want 0", b_out_valid); end
    if (b_in_ready !== 1) begin errors++; $display("FAIL reset b_in_ready: got %b want 1", b_in_ready); end
    if (c_out_valid !== 0) begin errors++; $display("FAIL reset c_out_valid: got %b want 0", c_out_valid); end
    if (c_in_ready !== 1) begin errors++; $display("FAIL reset c_in_ready: got %b want 1", c_in_ready); end
    if (c_out_data !== 0) begin errors++; $display("FAIL reset c_out_data: got %h want 0", c_out_data); end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_mc_l1;
    l1_column(16'h8421, 1'b0, "mc_l1");
  endtask

  task automatic test_bypass_l1;
    l1_column(16'h8421, 1'b1, "bypass_l1");
    l1_column(16'($urandom), 1'b0, "rand_mc_l1");
  endtask

  task automatic test_l4;
    logic [15:0] rnd, seq[3], want;
    logic [2:0] mode;
    rnd = 16'($urandom);
    seq[0] = 16'h8421; seq[1] = 16'h84AD; seq[2] = rnd;
    mode = 3'b100;
    c_out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      c_in_valid = (k < 3);
      c_in_data = seq[k%3];
      c_in_mode = mode[k%3];
      #1;
      checks++;
      if (c_in_ready !== 1) begin errors++; $display("FAIL l4_ready cycle%0d: got %b want 1", k, c_in_ready); end
      checks++;
      if (c_out_valid !== (k > 0)) begin errors++; $display("FAIL l4_valid cycle%0d: got %b want %b", k, c_out_valid, k > 0); end
      if (k > 0) begin
        want = mc(seq[k-1], mode[k-1]);
        checks++;
        if (c_out_data !== want) begin errors++; $display("FAIL l4_data col%0d: got %h want %h", k - 1, c_out_data, want); end
      end
    end
    c_in_valid = 0;
    @(negedge clk);
    #1;
    checks++;
    if (c_out_valid !== 0) begin errors++; $display("FAIL l4_drained: out_valid got %b want 0", c_out_valid); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] col[2], exp[2];
    logic [3:0] want;
    int i, got;
    col[0] = 16'($urandom); col[1] = 16'($urandom);
    exp[0] = mc(col[0], 1'b0); exp[1] = mc(col[1], 1'b1);
    i = 0; got = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      @(negedge clk);
      a_out_ready = (c >= 14);
      a_in_valid = (i < 8);
      a_in_data = col[(i/4)%2][4*(i%4) +: 4];
      a_in_mode = (i % 4 == 0) ? (i == 4) : (i < 4);
      #1;
      if (c >= 7 && c <= 16) begin
        checks++;
        if (a_in_ready !== 0) begin errors++; $display("FAIL bp_ready_low cycle%0d: got %b want 0", c, a_in_ready); end
      end
      if (c == 17) begin
        checks++;
        if (a_in_ready !== 1) begin errors++; $display("FAIL bp_ready_release cycle17: got %b want 1", a_in_ready); end
      end
      if (c >= 4 && c < 14) begin
        checks++;
        if (a_out_valid !== 1 || a_out_data !== exp[0][3:0]) begin
          errors++;
          $display("FAIL bp_hold cycle%0d: valid %b data %h want 1 %h", c, a_out_valid, a_out_data, exp[0][3:0]);
        end
      end
      if (a_out_valid && a_out_ready) begin
        want = exp[got/4][4*(got%4) +: 4];
        checks++;
        if (a_out_data !== want) begin errors++; $display("FAIL bp_data beat%0d: got %h want %h", got, a_out_data, want); end
        if (got == 4) begin
          checks++;
          if (c != 18) begin errors++; $display("FAIL bp_bubble: col2 started cycle %0d want 18", c); end
        end
        got++;
      end
      if (a_in_valid && a_in_ready) i++;
    end
    a_in_valid = 0;
    checks++;
    if (got != 8 || i != 8) begin errors++; $display("FAIL bp_timeout: out %0d in %0d want 8 8", got, i); end
  endtask

  task automatic test_reset_mid;
    a_out_ready = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      a_in_valid = 1; a_in_data = 4'hF - 4'(k); a_in_mode = 1;
    end
    @(negedge clk);
    a_in_valid = 0;
    rst_n = 0;
    #1;
    checks += 2;
    if (a_out_valid !== 0) begin errors++; $display("FAIL rst_mid_col valid: got %b want 0", a_out_valid); end
    if (a_in_ready !== 1) begin errors++; $display("FAIL rst_mid_col ready: got %b want 1", a_in_ready); end
    @(negedge clk);
    rst_n = 1;
    a_out_ready = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      a_in_valid = 1; a_in_data = 4'(k * 5 + 3); a_in_mode = 0;
    end
    @(negedge clk);
    a_in_valid = 0; a_out_ready = 1;
    @(negedge clk);
    a_out_ready = 0;
    #1;
    checks++;
    if (a_out_valid !== 1) begin errors++; $display("FAIL rst_drain setup: out_valid got %b want 1", a_out_valid); end
    rst_n = 0;
    #1;
    checks += 3;
    if (a_out_valid !== 0) begin errors++; $display("FAIL rst_drain valid: got %b want 0", a_out_valid); end
    if (a_in_ready !== 1) begin errors++; $display("FAIL rst_drain ready: got %b want 1", a_in_ready); end
    if (a_out_last !== 0) begin errors++; $display("FAIL rst_drain last: got %b want 0", a_out_last); end
    @(negedge clk);
    rst_n = 1;
    #1;
    checks++;
    if (a_out_valid !== 0) begin errors++; $display("FAIL rst_release valid: got %b want 0", a_out_valid); end
    l1_column(16'h8421, 1'b0, "after_reset");
  endtask

  task automatic test_random_l2;
    logic [15:0] cols[16];
    logic modes[16];
    logic [7:0] ins[32], exps[32], prev_data, want;
    logic prev_last, stalled;
    int i, got;
    for (int k = 0; k < 16; k++) begin
      cols[k] = 16'($urandom);
      modes[k] = 1'($urandom);
      for (int j = 0; j < 2; j++) begin
        ins[2*k+j] = cols[k][8*j +: 8];
        exps[2*k+j] = mc(cols[k], modes[k]) >> (8 * j);
      end
    end
    i = 0; got = 0; stalled = 0; prev_data = '0; prev_last = 0;
    for (int c = 0; c < 2000 && got < 32; c++) begin
      @(negedge clk);
      b_out_ready = 1'($urandom);
      b_in_valid = (i < 32) && ($urandom_range(0, 3) != 0);
      b_in_data = ins[i%32];
      b_in_mode = (i % 2 == 0) ? modes[(i/2)%16] : 1'($urandom);
      #1;
      if (b_out_valid && stalled) begin
        checks++;
        if (b_out_data !== prev_data || b_out_last !== prev_last) begin
          errors++;
          $display("FAIL l2_stall_stable beat%0d: got %h/%b want %h/%b", got, b_out_data, b_out_last, prev_data, prev_last);
        end
      end
      if (b_out_valid && b_out_ready) begin
        want = exps[got];
        checks += 2;
        if (b_out_data !== want) begin errors++; $display("FAIL l2_data beat%0d: got %h want %h", got, b_out_data, want); end
        if (b_out_last !== (got % 8 == 7)) begin
          errors++;
          $display("FAIL l2_last beat%0d: got %b want %b", got, b_out_last, got % 8 == 7);
        end
        got++;
        stalled = 0;
      end else stalled = b_out_valid;
      prev_data = b_out_data;
      prev_last = b_out_last;
      if (b_in_valid && b_in_ready) i++;
    end
    b_in_valid = 0;
    b_out_ready = 1;
    checks++;
    if (got != 32) begin errors++; $display("FAIL l2_count: got %0d beats want 32", got); end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (b_out_valid !== 0) begin errors++; $display("FAIL l2_duplicate: out_valid got %b want 0", b_out_valid); end
  endtask

  initial begin
    test_reset();
    test_mc_l1();
    test_bypass_l1();
    test_l4();
    test_back_to_back();
    test_reset_mid();
    test_random_l2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
